instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'd1, meaning the first program address fetched after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on the rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port pc, output, 16, the fetch address driven to the instruction ROM.
REQ-005 SHALL have port instruction, input, 9, the ROM word for the current pc, valid in the same cycle, formatted as {opcode[4:0], operand[3:0]}.
REQ-006 SHALL have port stall, input, 1, hold request from downstream.
REQ-007 SHALL have port redirect_valid, input, 1, branch or jump taken.
REQ-008 SHALL have port redirect_pc, input, 16, the target address for a redirect.
REQ-009 SHALL have port if_id_valid, output, 1, IF/ID register holds a real instruction.
REQ-010 SHALL have port if_id_opcode, output, 5, registered opcode.
REQ-011 SHALL have port if_id_operand, output, 4, registered operand.
REQ-012 SHALL have port if_id_pc, output, 16, address of the registered instruction.
REQ-013 SHALL have ports if_id_is_branch, if_id_is_jump and if_id_is_mem, each output, 1, registered decode flags.
REQ-014 SHALL have port halted, output, 1, high while in state HALTED.
REQ-015 SHALL have port fetch_count, output, 16, count of instructions accepted into IF/ID.

Function
REQ-016 SHALL implement two states, RUN and HALTED.
REQ-017 In RUN with stall=0 and redirect_valid=0, each edge SHALL:
- capture instruction and pc into IF/ID;
- set if_id_valid=1;
- set pc <= pc+1.
REQ-018 SHALL give instruction fetch a latency of one cycle: the instruction at pc appears on the if_id_* outputs after the next edge.
REQ-019 If the captured opcode is halt (5'b11010), the edge SHALL set state HALTED and hold pc at the halt address, with no increment.
REQ-020 In HALTED, absent a redirect, each edge SHALL set if_id_valid=0 and hold pc, so the halt instruction is delivered exactly once.
REQ-021 When stall=1 and redirect_valid=0, the edge SHALL hold pc, all if_id_* registers and fetch_count unchanged.
REQ-022 When redirect_valid=1, the edge SHALL set pc <= redirect_pc, if_id_valid <= 0 (one-bubble flush) and state <= RUN, regardless of stall or the current state.
REQ-023 A simultaneous redirect and stall SHALL resolve with redirect winning.
REQ-024 The decode flags SHALL be set as follows:
- is_branch=1 for opcodes 01111..10011 (be, bne, bez, bltz, bgte);
- is_jump=1 for 11000;
- is_mem=1 for 10110 and 10111 (ld, st);
- all flags 0 otherwise.
REQ-025 Flags SHALL be registered together with the opcode; when if_id_valid=0 all flags SHALL read 0.
REQ-026 pc SHALL wrap from 16'hFFFF to 16'h0000 on increment.
REQ-027 fetch_count SHALL increment on each edge that sets if_id_valid=1, saturating at 16'hFFFF.
REQ-028 Out-of-range ROM words (the ROM default, halt) SHALL need no special handling; the halt rule covers them.

Reset
REQ-029 On an edge with reset=1, the block SHALL set:
- pc=RESET_PC;
- state=RUN;
- if_id_valid=0;
- if_id_opcode=0, if_id_operand=0, if_id_pc=0;
- all flags 0;
- halted=0;
- fetch_count=0.
REQ-030 Reset SHALL override stall and redirect, including when asserted mid-stall or while HALTED.
REQ-031 The first instruction SHALL be captured on the first edge after reset deasserts.

Structure
REQ-032 The 5-bit opcode constants (add..toBeDefined) and the state encoding SHALL reside in shared package cpu_isa_pkg, also used by the instruction ROM and decode stage.
REQ-033 Opcode-to-flag decoding SHALL be a combinational sub-module, opcode_classifier, with input opcode[4:0] and outputs is_branch, is_jump and is_mem.

Verification
REQ-034 Scenario: reset, then 3 free-run cycles with the program ROM -> if_id_pc sequence 1,2,3; if_id_opcode 01110, 00110, 00000; fetch_count=3.
REQ-035 Scenario: stall=1 for 2 cycles at pc=5 -> pc stays 5; if_id holds pc 4; fetch_count unchanged.
REQ-036 Scenario: redirect_valid=1 with redirect_pc=90 while stall=1 -> next pc=90, if_id_valid=0; following edge if_id_pc=90, opcode 11001.
REQ-037 Scenario: fetch reaches pc=166 (ROM default halt) -> one valid halt with if_id_pc=166, then halted=1, if_id_valid=0, pc=166 held.
REQ-038 Scenario: in HALTED, redirect to 1 -> halted=0; fetching resumes at 1.
REQ-039 Scenario: redirect to 16'hFFFF with a non-halt word -> pc wraps to 0 on the next edge; reset mid-stream -> pc=1 and all outputs at their reset values.

Source files
------------

// File: rtl/cpu_isa_pkg.sv
// cpu_isa_pkg: opcode constants, fetch state encoding and decode flag bundle shared across the CPU
package cpu_isa_pkg;
  localparam logic [4:0] OP_BE   = 5'b01111;
  localparam logic [4:0] OP_BNE  = 5'b10000;
  localparam logic [4:0] OP_BEZ  = 5'b10001;
  localparam logic [4:0] OP_BLTZ = 5'b10010;
  localparam logic [4:0] OP_BGTE = 5'b10011;
  localparam logic [4:0] OP_LD   = 5'b10110;
  localparam logic [4:0] OP_ST   = 5'b10111;
  localparam logic [4:0] OP_JUMP = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b11010;
  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;
  typedef struct packed {
    logic is_branch;
    logic is_jump;
    logic is_mem;
  } op_flags_t;
endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: ROM, control and IF/ID signals of the fetch stage
interface instruction_fetch_if;
  logic [15:0] pc;
  logic [8:0]  instruction;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        if_id_valid;
  logic [4:0]  if_id_opcode;
  logic [3:0]  if_id_operand;
  logic [15:0] if_id_pc;
  logic        if_id_is_branch;
  logic        if_id_is_jump;
  logic        if_id_is_mem;
  logic        halted;
  logic [15:0] fetch_count;
  modport master (
    input  instruction, stall, redirect_valid, redirect_pc,
    output pc, if_id_valid, if_id_opcode, if_id_operand, if_id_pc,
           if_id_is_branch, if_id_is_jump, if_id_is_mem, halted, fetch_count
  );
  modport slave (
    output instruction, stall, redirect_valid, redirect_pc,
    input  pc, if_id_valid, if_id_opcode, if_id_operand, if_id_pc,
           if_id_is_branch, if_id_is_jump, if_id_is_mem, halted, fetch_count
  );
endinterface

// File: rtl/opcode_classifier.sv
// opcode_classifier: combinational opcode to branch/jump/mem flag decode
module opcode_classifier
  import cpu_isa_pkg::*;
(
  input  logic [4:0] opcode,
  output logic       is_branch,
  output logic       is_jump,
  output logic       is_mem
);
  assign is_branch = opcode >= OP_BE && opcode <= OP_BGTE;
  assign is_jump   = opcode == OP_JUMP;
  assign is_mem    = opcode == OP_LD || opcode == OP_ST;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: pc sequencing, halt/redirect/stall control and IF/ID register
module instruction_fetch
  import cpu_isa_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'd1
) (
  input logic          clk,
  input logic          reset,
  instruction_fetch_if.master bus
);
  logic [15:0] pc, ipc, count;
  logic [0:0]  state;
  logic        valid;
  logic [4:0]  op;
  logic [3:0]  opnd;
  op_flags_t   flags, dec;
  opcode_classifier u_cls (
    .opcode    (bus.instruction[8:4]),
    .is_branch (dec.is_branch),
    .is_jump   (dec.is_jump),
    .is_mem    (dec.is_mem)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      state <= ST_RUN;
      valid <= 1'b0;
      op    <= '0;
      opnd  <= '0;
      ipc   <= '0;
      flags <= '0;
      count <= '0;
    end else if (bus.redirect_valid) begin
      pc    <= bus.redirect_pc;
      state <= ST_RUN;
      valid <= 1'b0;
    end else if (!bus.stall) begin
      if (state == ST_HALTED) valid <= 1'b0;
      else begin
        op    <= bus.instruction[8:4];
        opnd  <= bus.instruction[3:0];
        ipc   <= pc;
        flags <= dec;
        valid <= 1'b1;
        count <= count + {15'd0, count != 16'hFFFF};
        if (bus.instruction[8:4] == OP_HALT) state <= ST_HALTED;
        else pc <= pc + 16'd1;
      end
    end
  end
  // flag registers may be stale across a flush, so qualify them with valid
  assign bus.pc              = pc;
  assign bus.if_id_valid     = valid;
  assign bus.if_id_opcode    = op;
  assign bus.if_id_operand   = opnd;
  assign bus.if_id_pc        = ipc;
  assign bus.if_id_is_branch = valid & flags.is_branch;
  assign bus.if_id_is_jump   = valid & flags.is_jump;
  assign bus.if_id_is_mem    = valid & flags.is_mem;
  assign bus.halted          = state == ST_HALTED;
  assign bus.fetch_count     = count;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed scenarios plus random stall/redirect/reset against a scoreboarded reference model
module tb_instruction_fetch;
  typedef struct packed {
    logic [15:0] pc;
    logic        v;
    logic [4:0]  op;
    logic [3:0]  opnd;
    logic [15:0] ipc;
    logic        br, jp, mem, halted;
    logic [15:0] cnt;
  } exp_t;
  logic clk, reset;
  int n_checks = 0, n_fail = 0;
  exp_t sb[$];
  logic [15:0] m_pc, m_ipc, m_cnt;
  logic        m_h, m_v;
  logic [4:0]  m_op;
  logic [3:0]  m_opnd;
  instruction_fetch_if bus ();
  instruction_fetch #(.RESET_PC(16'd1)) dut (.clk(clk), .reset(reset), .bus(bus));
  function automatic logic [8:0] rom(input logic [15:0] a);
    logic [4:0] o;
    if (a == 16'd1) return {5'b01110, 4'h3};
    if (a == 16'd2) return {5'b00110, 4'h5};
    if (a == 16'd3) return {5'b00000, 4'h0};
    if (a == 16'd90) return {5'b11001, 4'h7};
    if (a == 16'hFFFF) return {5'b00001, 4'hF};
    if (a >= 16'd166) return {5'b11010, 4'h0};
    o = 5'((int'(a) * 7 + 3) % 26);
    return {o, a[3:0]};
  endfunction
  assign bus.instruction = rom(bus.pc);
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask
  task automatic step(input logic r, input logic s, input logic rv, input logic [15:0] rp);
    logic [8:0] w;
    exp_t e;
    @(negedge clk);
    reset = r;
    bus.stall = s;
    bus.redirect_valid = rv;
    bus.redirect_pc = rp;
    if (r) begin
      m_pc = 16'd1; m_h = 0; m_v = 0; m_op = 0; m_opnd = 0; m_ipc = 0; m_cnt = 0;
    end else if (rv) begin
      m_pc = rp; m_v = 0; m_h = 0;
    end else if (!s) begin
      if (m_h) m_v = 0;
      else begin
        w = rom(m_pc);
        m_op = w[8:4]; m_opnd = w[3:0]; m_ipc = m_pc; m_v = 1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (m_op == 5'd26) m_h = 1;
        else m_pc = m_pc + 16'd1;
      end
    end
    e.pc = m_pc; e.v = m_v; e.op = m_op; e.opnd = m_opnd; e.ipc = m_ipc;
    e.br = m_v && m_op >= 5'd15 && m_op <= 5'd19;
    e.jp = m_v && m_op == 5'd24;
    e.mem = m_v && (m_op == 5'd22 || m_op == 5'd23);
    e.halted = m_h; e.cnt = m_cnt;
    sb.push_back(e);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc", bus.pc, e.pc);
        chk("if_id_valid", 16'(bus.if_id_valid), 16'(e.v));
        chk("if_id_opcode", 16'(bus.if_id_opcode), 16'(e.op));
        chk("if_id_operand", 16'(bus.if_id_operand), 16'(e.opnd));
        chk("if_id_pc", bus.if_id_pc, e.ipc);
        chk("is_branch", 16'(bus.if_id_is_branch), 16'(e.br));
        chk("is_jump", 16'(bus.if_id_is_jump), 16'(e.jp));
        chk("is_mem", 16'(bus.if_id_is_mem), 16'(e.mem));
        chk("halted", 16'(bus.halted), 16'(e.halted));
        chk("fetch_count", bus.fetch_count, e.cnt);
      end
    end
  end
  initial begin
    reset = 1; bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
    step(1, 0, 0, 0); step(1, 1, 1, 16'd50);
    repeat (4) step(0, 0, 0, 0);
    repeat (2) step(0, 1, 0, 0);
    step(0, 1, 1, 16'd90);
    step(0, 0, 0, 0);
    step(0, 0, 1, 16'd160);
    repeat (10) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 16'd1);
    repeat (4) step(0, 0, 0, 0);
    step(0, 0, 1, 16'hFFFF);
    repeat (3) step(0, 0, 0, 0);
    step(1, 1, 1, 16'd77);
    step(0, 0, 1, 16'd165);
    repeat (4) step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 200)));
    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
